// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions used by the memory-side blocks.
// Provides line/word/mask types, line geometry constants and the
// pmem_adapter state encoding.
package lc3b_types;

    localparam int unsigned LINE_OFFSET_BITS = 4;
    localparam int unsigned WORDS_PER_LINE   = 8;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
    typedef logic [1:0]   lc3b_mem_wmask;
    typedef logic [2:0]   lc3b_word_idx;
    typedef logic [15-LINE_OFFSET_BITS:0] lc3b_line_tag;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITEBACK,
        S_RESP
    } pmem_state_e;

endpackage

// File: rtl/line_word_merge.sv
// line_word_merge: combinational word select and byte-masked word merge
// on a 128-bit line (word 0 at bits [15:0]).
// Ports:
//   line        in   source line
//   word_idx    in   word index within the line
//   wdata       in   write word
//   wmask       in   byte mask; [0] low byte, [1] high byte
//   word        out  line word at word_idx
//   merged_line out  line with wdata merged into word_idx per wmask
module line_word_merge
    import lc3b_types::*;
(
    input  lc3b_line      line,
    input  lc3b_word_idx  word_idx,
    input  lc3b_word      wdata,
    input  lc3b_mem_wmask wmask,
    output lc3b_word      word,
    output lc3b_line      merged_line
);

    always_comb begin
        word        = '0;
        merged_line = line;
        for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
            if (i == 32'(word_idx)) begin
                word = line[i*16 +: 16];
                if (wmask[0]) merged_line[i*16 +: 8]     = wdata[7:0];
                if (wmask[1]) merged_line[i*16 + 8 +: 8] = wdata[15:8];
            end
        end
    end

endmodule

// File: rtl/pmem_adapter.sv
// pmem_adapter: bridges the 16-bit arbiter memory port to 128-bit line-wide
// physical memory. Reads become line fills with word select; writes become
// line read-modify-write (fill, merge, writeback).
// Optional feature macro: LINE_BUF_EN adds a one-line read buffer so read
// hits to the most recently filled/written line complete without pmem access.
// Ports:
//   clk, rst                      clock, async active-high reset
//   mem_address/read/write        word-side request (sampled only in IDLE)
//   mem_byte_enable, mem_wdata    write mask and data
//   mem_rdata, mem_resp           read data and one-cycle completion
//   pmem_address/read/write       line-side request (line aligned)
//   pmem_wdata, pmem_rdata        line write / read data
//   pmem_resp                     physical memory completion
module pmem_adapter
    import lc3b_types::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    pmem_state_e   state, state_next;

    lc3b_line_tag  req_tag;
    lc3b_word_idx  req_idx;
    lc3b_word      req_wdata;
    lc3b_mem_wmask req_wmask;
    logic          req_write;
    lc3b_line      line_q;

    lc3b_line      merge_in;
    lc3b_line      merged;
    lc3b_word      sel_word;
    logic          buf_hit;
    logic          mem_req;
    logic          addr_lsb_unused;

    assign addr_lsb_unused = mem_address[0];
    assign mem_req         = mem_read | mem_write;

`ifdef LINE_BUF_EN
    logic         buf_valid;
    lc3b_line_tag buf_tag;
    lc3b_line     buf_data;

    // A request with mem_write set is a write even if mem_read is also set.
    assign buf_hit = mem_read && !mem_write && buf_valid &&
                     (buf_tag == mem_address[15:LINE_OFFSET_BITS]);
`else
    assign buf_hit = 1'b0;
`endif

    // During FILL the merge operates on the incoming line so the merged
    // result can be latched on the pmem_resp edge; otherwise on the held line.
    assign merge_in = (state == S_FILL) ? pmem_rdata : line_q;

    line_word_merge u_merge (
        .line        (merge_in),
        .word_idx    (req_idx),
        .wdata       (req_wdata),
        .wmask       (req_wmask),
        .word        (sel_word),
        .merged_line (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        unique case (state)
            S_IDLE: begin
                if (mem_req) state_next = buf_hit ? S_RESP : S_FILL;
            end
            S_FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, 4'h0};
                if (pmem_resp) state_next = req_write ? S_WRITEBACK : S_RESP;
            end
            S_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {req_tag, 4'h0};
                pmem_wdata   = line_q;
                if (pmem_resp) state_next = S_RESP;
            end
            S_RESP: begin
                mem_resp   = 1'b1;
                mem_rdata  = sel_word;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_tag   <= '0;
            req_idx   <= '0;
            req_wdata <= '0;
            req_wmask <= '0;
            req_write <= 1'b0;
            line_q    <= '0;
`ifdef LINE_BUF_EN
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_req) begin
                        req_tag   <= mem_address[15:LINE_OFFSET_BITS];
                        req_idx   <= mem_address[3:1];
                        req_wdata <= mem_wdata;
                        req_wmask <= mem_byte_enable;
                        req_write <= mem_write;
`ifdef LINE_BUF_EN
                        if (buf_hit) line_q <= buf_data;
`endif
                    end
                end
                S_FILL: begin
                    if (pmem_resp) begin
                        line_q <= req_write ? merged : pmem_rdata;
`ifdef LINE_BUF_EN
                        // Loading the post-merge line covers both the
                        // tag-match update and the fresh load on writes.
                        buf_valid <= 1'b1;
                        buf_tag   <= req_tag;
                        buf_data  <= req_write ? merged : pmem_rdata;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_adapter.sv
module tb_pmem_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [127:0] l1;
    logic [127:0] l3;

    pmem_adapter dut (
        .clk             (clk),
        .rst             (rst),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request for one sampling edge, then withdraw it.
    task automatic request(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [1:0] be);
        @(posedge clk);
        #1;
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_wdata       = wdata;
        mem_byte_enable = be;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = 16'h0000;
    endtask

    // Called from a negedge: wait some edges, then pulse pmem_resp for one edge.
    task automatic reply(input logic [127:0] data, input int unsigned delay);
        repeat (delay) @(posedge clk);
        #1;
        pmem_resp  = 1'b1;
        pmem_rdata = data;
        @(posedge clk);
        #1;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            l1[i*16 +: 16] = 16'h1100 + 16'(i);
            l3[i*16 +: 16] = 16'h3300 + 16'(i);
        end
        l1[63:48] = 16'hBEEF;

        rst = 1'b0;
        mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable = '0; mem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_mem_resp",   mem_resp, 0);
        check("reset_mem_rdata",  mem_rdata, 0);
        check("reset_pmem_read",  pmem_read, 0);
        check("reset_pmem_write", pmem_write, 0);
        check("reset_pmem_addr",  pmem_address, 0);
        check("reset_pmem_wdata", pmem_wdata, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Read miss 0x1236 -> word 3
        request(1'b1, 1'b0, 16'h1236, 16'h0, 2'b00);
        @(negedge clk);
        check("rd_pmem_read",  pmem_read, 1);
        check("rd_pmem_addr",  pmem_address, 16'h1230);
        check("rd_no_resp",    mem_resp, 0);
        reply(l1, 2);
        @(negedge clk);
        check("rd_mem_resp",   mem_resp, 1);
        check("rd_mem_rdata",  mem_rdata, 16'hBEEF);
        check("rd_pmem_drop",  pmem_read, 0);
        @(negedge clk);
        check("rd_resp_1cyc",  mem_resp, 0);

        // Write 0x2002, low byte only, over an all-ones line
        request(1'b0, 1'b1, 16'h2002, 16'hAB12, 2'b01);
        @(negedge clk);
        check("wr_fill_read",  pmem_read, 1);
        check("wr_fill_nowr",  pmem_write, 0);
        check("wr_fill_addr",  pmem_address, 16'h2000);
        reply({128{1'b1}}, 1);
        @(negedge clk);
        check("wr_wb_write",   pmem_write, 1);
        check("wr_wb_noread",  pmem_read, 0);
        check("wr_wb_addr",    pmem_address, 16'h2000);
        check("wr_wb_wdata",   pmem_wdata, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF12_FFFF);
        check("wr_wb_noresp",  mem_resp, 0);
        reply('0, 2);
        @(negedge clk);
        check("wr_mem_resp",   mem_resp, 1);
        @(negedge clk);
        check("wr_resp_1cyc",  mem_resp, 0);

        // Read and write both high -> write
        request(1'b1, 1'b1, 16'h4004, 16'h5678, 2'b11);
        @(negedge clk);
        check("both_fill",     pmem_read, 1);
        reply('0, 0);
        @(negedge clk);
        check("both_wb",       pmem_write, 1);
        check("both_wdata",    pmem_wdata, 128'h0000_0000_0000_0000_0000_5678_0000_0000);
        reply('0, 0);
        @(negedge clk);
        check("both_resp",     mem_resp, 1);
        check("both_rdata",    mem_rdata, 16'h5678);

        // Write with empty mask: line written back unchanged
        request(1'b0, 1'b1, 16'h6006, 16'h1234, 2'b00);
        @(negedge clk);
        check("be0_fill",      pmem_read, 1);
        reply(l1, 1);
        @(negedge clk);
        check("be0_wb",        pmem_write, 1);
        check("be0_wdata",     pmem_wdata, l1);
        reply('0, 1);
        @(negedge clk);
        check("be0_resp",      mem_resp, 1);

        // Spurious pmem_resp in IDLE
        @(posedge clk);
        #1 pmem_resp = 1'b1;
        @(posedge clk);
        #1 pmem_resp = 1'b0;
        @(negedge clk);
        check("spur_resp",     mem_resp, 0);
        check("spur_read",     pmem_read, 0);
        check("spur_write",    pmem_write, 0);
        @(negedge clk);
        check("spur_resp2",    mem_resp, 0);

        // Reset mid-FILL
        request(1'b1, 1'b0, 16'h5000, 16'h0, 2'b00);
        @(negedge clk);
        check("rstf_read",     pmem_read, 1);
        #1 rst = 1'b1;
        #1;
        check("rstf_drop",     pmem_read, 0);
        check("rstf_addr",     pmem_address, 0);
        check("rstf_noresp",   mem_resp, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstf_idle_resp", mem_resp, 0);
            check("rstf_idle_read", pmem_read, 0);
        end
        request(1'b1, 1'b0, 16'h5000, 16'h0, 2'b00);
        @(negedge clk);
        check("rstf_refill",   pmem_read, 1);
        reply(l1, 1);
        @(negedge clk);
        check("rstf_resp",     mem_resp, 1);
        check("rstf_rdata",    mem_rdata, 16'h1100);

`ifdef LINE_BUF_EN
        request(1'b1, 1'b0, 16'h3000, 16'h0, 2'b00);
        @(negedge clk);
        check("buf_fill",      pmem_read, 1);
        reply(l3, 1);
        @(negedge clk);
        check("buf_rd0",       mem_rdata, 16'h3300);
        request(1'b1, 1'b0, 16'h3008, 16'h0, 2'b00);
        @(negedge clk);
        check("buf_hit_resp",  mem_resp, 1);
        check("buf_hit_nord",  pmem_read, 0);
        check("buf_hit_data",  mem_rdata, 16'h3304);
        request(1'b0, 1'b1, 16'h3008, 16'h9999, 2'b11);
        @(negedge clk);
        check("buf_wr_fill",   pmem_read, 1);
        reply(l3, 0);
        @(negedge clk);
        check("buf_wr_wb",     pmem_write, 1);
        reply('0, 0);
        @(negedge clk);
        check("buf_wr_resp",   mem_resp, 1);
        request(1'b1, 1'b0, 16'h3008, 16'h0, 2'b00);
        @(negedge clk);
        check("buf_rw_resp",   mem_resp, 1);
        check("buf_rw_nord",   pmem_read, 0);
        check("buf_rw_data",   mem_rdata, 16'h9999);
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
